// File: rtl/rfsoc_config_pkg.sv
// Shared types and constants for the RFSoC ADC readout path.
package rfsoc_config;

    localparam logic [15:0] ADC_ARB_MAGIC = 16'hADC0;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BURST
    } arb_state_t;

    // Channel-id field is never narrower than the 3-bit tuser sideband.
    function automatic int ch_id_width(input int num_ch);
        int w;
        w = $clog2(num_ch);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer; breaks the ready path and keeps full rate.
module axis_skid_buffer #(
    parameter int W = 132
) (
    input  logic         pl_clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] skid_data;
    logic         skid_valid;

    assign s_ready = !skid_valid;

    // The output register refills from the skid entry first so beat order is kept.
    always_ff @(posedge pl_clk) begin
        if (rst || clear) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!m_valid || m_ready) begin
            if (skid_valid) begin
                m_data     <= skid_data;
                m_valid    <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                m_valid <= s_valid;
                if (s_valid) begin
                    m_data <= s_data;
                end
            end
        end else if (s_valid && !skid_valid) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_readout_arbiter.sv
// Round-robin arbiter multiplexing NUM_CH ADC streams onto one tagged AXI-Stream.
// Define ADC_ARB_HEADER_EN to prefix every grant with a magic/id/sequence header beat.
module adc_readout_arbiter
    import rfsoc_config::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 16
) (
    input  logic                     pl_clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     flush,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [2:0]               m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic                     busy
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ID_W   = ch_id_width(NUM_CH);
    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int SKID_W = DATA_W + 1 + ID_W;

    arb_state_t        state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [NUM_CH-1:0] req;
    logic [CH_W-1:0]   pick;
    logic              pick_valid;
    logic [CH_W:0]     scan_idx;
    logic [ID_W-1:0]   grant_id;
    logic              beat_last;
    logic              in_hs;
    logic [SKID_W-1:0] sk_in_data;
    logic              sk_in_valid;
    logic              sk_in_ready;
    logic [SKID_W-1:0] sk_out_data;

`ifdef ADC_ARB_HEADER_EN
    logic [15:0]       seq_cnt [NUM_CH];
    logic [DATA_W-1:0] header;

    always_comb begin
        header                   = '0;
        header[DATA_W-1 -: 16]   = ADC_ARB_MAGIC;
        header[DATA_W-17 -: 8]   = {{(8-ID_W){1'b0}}, grant_id};
        header[15:0]             = seq_cnt[grant];
    end
`endif

    assign req = s_axis_tvalid & ch_enable;

    // First requester at or above rr_ptr, wrapping back to channel 0.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (scan_idx >= (CH_W+1)'(NUM_CH)) begin
                scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
            end
            if (!pick_valid && req[scan_idx[CH_W-1:0]]) begin
                pick       = scan_idx[CH_W-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant_id             = '0;
        grant_id[CH_W-1:0]   = grant;
    end

    assign beat_last = s_axis_tlast[grant] || (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign in_hs     = (state == BURST) && !flush && s_axis_tvalid[grant] && sk_in_ready;

    always_comb begin
        sk_in_valid = 1'b0;
        sk_in_data  = {grant_id, beat_last, s_axis_tdata[grant*DATA_W +: DATA_W]};
        if (!flush) begin
            case (state)
                BURST:  sk_in_valid = s_axis_tvalid[grant];
`ifdef ADC_ARB_HEADER_EN
                HEADER: begin
                    sk_in_valid = 1'b1;
                    sk_in_data  = {grant_id, 1'b0, header};
                end
`endif
                default: sk_in_valid = 1'b0;
            endcase
        end
    end

    // While flushing every channel is drained so upstream FIFOs empty out.
    always_comb begin
        s_axis_tready = '0;
        if (!rst) begin
            if (flush) begin
                s_axis_tready = '1;
            end else if (state == BURST) begin
                s_axis_tready[grant] = sk_in_ready;
            end
        end
    end

    always_ff @(posedge pl_clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
`ifdef ADC_ARB_HEADER_EN
            for (int i = 0; i < NUM_CH; i++) begin
                seq_cnt[i] <= '0;
            end
`endif
        end else if (flush) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (pick_valid) begin
                        grant <= pick;
`ifdef ADC_ARB_HEADER_EN
                        state <= HEADER;
`else
                        state <= BURST;
`endif
                    end
                end
`ifdef ADC_ARB_HEADER_EN
                HEADER: begin
                    if (sk_in_ready) begin
                        state <= BURST;
                    end
                end
`endif
                BURST: begin
                    if (in_hs) begin
                        if (beat_last) begin
                            state  <= IDLE;
                            rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
`ifdef ADC_ARB_HEADER_EN
                            seq_cnt[grant] <= seq_cnt[grant] + 16'd1;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .W(SKID_W)
    ) u_skid (
        .pl_clk  (pl_clk),
        .rst     (rst),
        .clear   (flush),
        .s_data  (sk_in_data),
        .s_valid (sk_in_valid),
        .s_ready (sk_in_ready),
        .m_data  (sk_out_data),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = sk_out_data[DATA_W-1:0];
    assign m_axis_tlast = sk_out_data[DATA_W];
    assign m_axis_tuser = sk_out_data[DATA_W+1 +: 3];
    assign busy         = (state != IDLE);

endmodule
